// File: rtl/preadder_align_if.sv
// Operand-in / aligned-out handshake bundle for the float-add alignment front end.
// slave is the aligner side, master is the producer/consumer side.
interface preadder_align_if #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       a;
  logic [31:0]       b;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mantis_big;
  logic [MANT_W-1:0] mantis_small;
  logic              sign_big;
  logic              sub_op;
  logic              special;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, exp_out,
    output mantis_big, mantis_small,
    output sign_big, sub_op, special
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, exp_out,
    input  mantis_big, mantis_small,
    input  sign_big, sub_op, special
  );
endinterface

// File: rtl/preadder_align.sv
// Two-stage operand alignment for the float adder: unpack and order by magnitude,
// then right-shift the smaller mantissa to the common exponent with sticky collapse.
module preadder_align #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 8
) (
  input  logic clk,
  input  logic rst,
  preadder_align_if.slave io
);

  localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(MANT_W);

  logic              acc;
  logic              s2_ready;

  logic              s1_valid_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic [EXP_W-1:0]  s1_diff_q;
  logic [MANT_W-1:0] s1_mbig_q;
  logic [MANT_W-1:0] s1_msmall_q;
  logic              s1_sign_q;
  logic              s1_sub_q;
  logic              s1_spec_q;

  logic [EXP_W-1:0]  s1_exp_d;
  logic [EXP_W-1:0]  s1_diff_d;
  logic [MANT_W-1:0] s1_mbig_d;
  logic [MANT_W-1:0] s1_msmall_d;
  logic              s1_sign_d;
  logic              s1_sub_d;
  logic              s1_spec_d;

  logic              out_valid_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] mbig_q;
  logic [MANT_W-1:0] msmall_q;
  logic              sign_q;
  logic              sub_q;
  logic              spec_q;

  logic [MANT_W-1:0] msmall_d;

  logic [EXP_W-1:0]  ea_raw;
  logic [EXP_W-1:0]  eb_raw;
  logic [EXP_W-1:0]  ea;
  logic [EXP_W-1:0]  eb;
  logic [MANT_W-1:0] ma;
  logic [MANT_W-1:0] mb;
  logic              swap;

  logic [MANT_W-1:0] sh;
  logic [MANT_W-1:0] mask;
  logic              lost;

  assign s2_ready    = !out_valid_q || io.out_ready;
  assign io.in_ready = !s1_valid_q || s2_ready;
  assign acc         = io.in_valid && io.in_ready;

  // Denormals use exponent 1 with no hidden bit.
  always_comb begin
    ea_raw = io.a[30:23];
    eb_raw = io.b[30:23];
    ea     = (ea_raw == '0) ? EXP_W'(1) : ea_raw;
    eb     = (eb_raw == '0) ? EXP_W'(1) : eb_raw;
    ma     = {1'b0, |ea_raw, io.a[22:0], 3'b000};
    mb     = {1'b0, |eb_raw, io.b[22:0], 3'b000};
    swap   = io.b[30:0] > io.a[30:0];
  end

  always_comb begin
    s1_exp_d    = ea;
    s1_diff_d   = ea - eb;
    s1_mbig_d   = ma;
    s1_msmall_d = mb;
    s1_sign_d   = io.a[31];
    if (swap) begin
      s1_exp_d    = eb;
      s1_diff_d   = eb - ea;
      s1_mbig_d   = mb;
      s1_msmall_d = ma;
      s1_sign_d   = io.b[31];
    end
    s1_sub_d  = io.a[31] ^ io.b[31];
    s1_spec_d = (&ea_raw) || (&eb_raw);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_exp_q    <= '0;
      s1_diff_q   <= '0;
      s1_mbig_q   <= '0;
      s1_msmall_q <= '0;
      s1_sign_q   <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_spec_q   <= 1'b0;
    end else begin
      if (io.in_ready) begin
        s1_valid_q <= io.in_valid;
      end
      if (acc) begin
        s1_exp_q    <= s1_exp_d;
        s1_diff_q   <= s1_diff_d;
        s1_mbig_q   <= s1_mbig_d;
        s1_msmall_q <= s1_msmall_d;
        s1_sign_q   <= s1_sign_d;
        s1_sub_q    <= s1_sub_d;
        s1_spec_q   <= s1_spec_d;
      end
    end
  end

  // Any bit shifted past bit0 folds into the sticky position.
  always_comb begin
    sh   = s1_msmall_q >> s1_diff_q;
    mask = ~({MANT_W{1'b1}} << s1_diff_q);
    lost = |(s1_msmall_q & mask);
    if (s1_diff_q == '0) begin
      msmall_d = s1_msmall_q;
    end else if (s1_diff_q < SH_MAX) begin
      msmall_d = {sh[MANT_W-1:1], sh[0] | lost};
    end else begin
      msmall_d = {{(MANT_W-1){1'b0}}, |s1_msmall_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      exp_q       <= '0;
      mbig_q      <= '0;
      msmall_q    <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      spec_q      <= 1'b0;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        exp_q    <= s1_exp_q;
        mbig_q   <= s1_mbig_q;
        msmall_q <= msmall_d;
        sign_q   <= s1_sign_q;
        sub_q    <= s1_sub_q;
        spec_q   <= s1_spec_q;
      end
    end
  end

  assign io.out_valid    = out_valid_q;
  assign io.exp_out      = exp_q;
  assign io.mantis_big   = mbig_q;
  assign io.mantis_small = msmall_q;
  assign io.sign_big     = sign_q;
  assign io.sub_op       = sub_q;
  assign io.special      = spec_q;

endmodule

// File: doc/preadder_align.md
Name: preadder_align

Overview:
- Two-stage pipelined operand-alignment front end of the float adder, upstream of the mantissa add/normalize stage.
- Accepts two IEEE-754 single-precision words and unpacks them into the 28-bit internal mantissa format.
- Orders the operands by magnitude and right-shifts the smaller mantissa to the larger exponent, with sticky collapse.
- Valid/ready handshake on both sides; stalls without dropping data.

Parameters:
- MANT_W, 28, internal mantissa width: bit27 carry headroom, bit26 hidden bit, bits25:3 fraction, bits2:0 guard/round/sticky.
- EXP_W, 8, exponent width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- a  in  32  IEEE-754 operand A.
- b  in  32  IEEE-754 operand B.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts the result.
- exp_out  out  8  common (larger) exponent.
- mantis_big  out  28  mantissa of the larger-magnitude operand, unshifted.
- mantis_small  out  28  mantissa of the smaller operand, aligned, with sticky in bit0.
- sign_big  out  1  sign of the larger-magnitude operand.
- sub_op  out  1  1 when the operand signs differ (effective subtract).
- special  out  1  either operand has exponent 255 (Inf/NaN); the datapath still passes values through.

Behaviour:
- Reset (async, any time): both stage valid bits are 0 and all output registers are 0. out_valid=0 and in_ready=1 on the first cycle after reset is released. A transaction in flight is discarded.
- Handshake: a pair is accepted when in_valid && in_ready. The result is consumed when out_valid && out_ready.
- Stall rule: s2_ready = !out_valid || out_ready; in_ready = !s1_valid || s2_ready. in_ready is combinational from out_ready.
- Output data is held stable while out_valid && !out_ready.
- Latency: 2 cycles from acceptance to out_valid with no stall. Throughput is 1 pair per cycle.
- Stage 1 (register at accept):
  - Unpack each operand: e = x[30:23]; hidden = (e != 0); effective exp = (e == 0) ? 1 : e.
  - mantis = {1'b0, hidden, x[22:0], 3'b000}.
  - swap = (b[30:0] > a[30:0]) unsigned. On a tie, A is big.
  - Register big/small exp, mantissas, signs, special, and sub_op = a[31] ^ b[31].
  - diff = exp_big - exp_small, 8-bit unsigned, never negative by construction.
- Stage 2 (register when s2_ready):
  - If diff == 0: mantis_small is unchanged.
  - If 1 <= diff <= 27: mantis_small = (m >> diff), with bit0 ORed with the OR of all bits shifted out.
  - If diff >= 28: mantis_small = {27'b0, |m}.
  - exp_out = exp_big.
- Zero operand: exp 0 with fraction 0 gives mantis 0, so sticky stays 0.
- Simultaneous accept and consume while full: both stages advance in the same cycle, with no bubble and no loss.

Test Plan:
- a=0x3F800000, b=0x3F000000 -> after 2 cycles: exp_out=127, mantis_big=0x4000000, mantis_small=0x2000000, sub_op=0, special=0.
- a=0x3F800001, b=0x41800000 (swap, diff 4) -> exp_out=131, mantis_big=0x4000000, mantis_small=0x0400001 (sticky set), sign_big=0.
- a=0x53800000 (exp 167), b=0x3F800000 -> mantis_small=0x0000001. Same test with b=0 -> mantis_small=0x0000000.
- a=0xBF800000, b=0x3F800000 -> tie, A big: sign_big=1, sub_op=1, mantis_small=0x4000000. a=0x7F800000 -> special=1.
- Stream 4 pairs with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, out_valid data held stable, then all 4 results emerge in order with no duplicates.
- Assert rst while both stages are full -> out_valid=0 and outputs=0 immediately; in_ready=1 after release; the next pair emerges 2 cycles after acceptance.
